// File: rtl/sicaklik_pkg.sv
// Shared definitions for the temperature alarm path: FSM encoding, comparator width and
// small helpers used by the alarm controller.
package sicaklik_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_ACKED   = 2'd3;

  // Temperature / threshold width used by the upstream comparator.
  localparam int unsigned TEMP_W = 3;

  function automatic logic is_alarm_state(input logic [1:0] st);
    return (st == ST_ACTIVE) || (st == ST_ACKED);
  endfunction

endpackage

// File: rtl/sicaklik_blink.sv
// Lamp toggle generator: restarts high, flips every BLINK_HALF enabled cycles,
// and clears to 0 whenever neither enabled nor restarted.
module sicaklik_blink #(
  parameter int unsigned BLINK_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_blink
);

  localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BLINK_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic          r_blink;
  logic          w_blink_d;

  always_comb begin
    w_cnt_d   = '0;
    w_blink_d = 1'b0;
    if (i_restart) begin
      w_cnt_d   = RELOAD;
      w_blink_d = 1'b1;
    end else if (i_en) begin
      if (r_cnt == '0) begin
        w_cnt_d   = RELOAD;
        w_blink_d = ~r_blink;
      end else begin
        w_cnt_d   = r_cnt - CW'(1);
        w_blink_d = r_blink;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_blink <= w_blink_d;
    end
  end

  assign o_blink = r_blink;

endmodule

// File: rtl/sicaklik_alarm_ctrl.sv
// Over-temperature alarm controller: debounces the comparator alarm, latches confirmed
// events into the buzzer/lamp until acknowledged and cleared, and counts events.
module sicaklik_alarm_ctrl
  import sicaklik_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_HALF      = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alarm_in,
  input  logic             ack,
  output logic             buzzer,
  output logic             led,
  output logic             alarm_active,
  output logic [CNT_W-1:0] event_count,
  output logic [1:0]       state
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [DEB_W-1:0] w_deb_cnt_d;
  logic [CNT_W-1:0] r_event_cnt;
  logic [CNT_W-1:0] w_event_cnt_d;
  logic             r_buzzer;
  logic             r_alarm_active;
  logic             w_blink;
  logic             w_enter_active;
  logic             w_stay_active;

  always_comb begin
    w_state_d     = r_state;
    w_deb_cnt_d   = '0;
    w_event_cnt_d = r_event_cnt;
    case (r_state)
      ST_IDLE: begin
        if (alarm_in) begin
          w_state_d   = ST_PENDING;
          w_deb_cnt_d = DEB_W'(1);
        end
      end
      ST_PENDING: begin
        if (!alarm_in) begin
          w_state_d = ST_IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          // Confirming edge wins over a simultaneous ack.
          w_state_d = ST_ACTIVE;
          if (r_event_cnt != '1) begin
            w_event_cnt_d = r_event_cnt + CNT_W'(1);
          end
        end else begin
          w_deb_cnt_d = r_deb_cnt + DEB_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (ack) begin
          w_state_d = ST_ACKED;
        end
      end
      ST_ACKED: begin
        if (!alarm_in) begin
          w_state_d = ST_IDLE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_deb_cnt      <= '0;
      r_event_cnt    <= '0;
      r_buzzer       <= 1'b0;
      r_alarm_active <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_deb_cnt      <= w_deb_cnt_d;
      r_event_cnt    <= w_event_cnt_d;
      r_buzzer       <= (w_state_d == ST_ACTIVE);
      r_alarm_active <= is_alarm_state(w_state_d);
    end
  end

  assign w_enter_active = (w_state_d == ST_ACTIVE) && (r_state != ST_ACTIVE);
  assign w_stay_active  = (w_state_d == ST_ACTIVE) && (r_state == ST_ACTIVE);

  sicaklik_blink #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_stay_active),
    .i_restart (w_enter_active),
    .o_blink   (w_blink)
  );

  // Blink register is forced to 0 outside ACTIVE, so the OR only adds the steady ACKED lamp.
  assign led          = w_blink | (r_state == ST_ACKED);
  assign buzzer       = r_buzzer;
  assign alarm_active = r_alarm_active;
  assign event_count  = r_event_cnt;
  assign state        = r_state;

endmodule

// File: tb/tb_sicaklik_alarm_ctrl.sv
// Bench for sicaklik_alarm_ctrl: directed scenarios then random alarm/ack traffic, both
// checked against an event-level model; a second instance with CNT_W=2 covers saturation.
module tb_sicaklik_alarm_ctrl;

  localparam int DEB = 4;
  localparam int BH  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alarm_in = 1'b0;
  logic       ack = 1'b0;
  logic       buzzer, led, alarm_active;
  logic [7:0] event_count;
  logic [1:0] state;
  logic       buzzer2, led2, alarm_active2;
  logic [1:0] event_count2;
  logic [1:0] state2;

  sicaklik_alarm_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BH), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alarm_in     (alarm_in),
    .ack          (ack),
    .buzzer       (buzzer),
    .led          (led),
    .alarm_active (alarm_active),
    .event_count  (event_count),
    .state        (state)
  );

  sicaklik_alarm_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BH), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .alarm_in     (alarm_in),
    .ack          (ack),
    .buzzer       (buzzer2),
    .led          (led2),
    .alarm_active (alarm_active2),
    .event_count  (event_count2),
    .state        (state2)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Model: an event is "latched" once DEB consecutive highs are seen, "acked" after ack.
  bit m_latched = 1'b0;
  bit m_acked   = 1'b0;
  int m_run     = 0;
  int m_events  = 0;
  int m_entry   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_latched = 1'b0;
    m_acked   = 1'b0;
    m_run     = 0;
    m_events  = 0;
  endtask

  task automatic model_edge(input bit a, input bit k);
    if (m_acked) begin
      if (!a) begin
        m_acked   = 1'b0;
        m_latched = 1'b0;
      end
    end else if (m_latched) begin
      if (k) m_acked = 1'b1;
    end else if (a) begin
      m_run++;
      if (m_run == DEB) begin
        m_latched = 1'b1;
        m_run     = 0;
        m_events++;
        m_entry   = cyc;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_all();
    int exp_st;
    bit exp_led;
    exp_st  = m_acked ? 3 : m_latched ? 2 : (m_run > 0) ? 1 : 0;
    exp_led = m_acked ? 1'b1 :
              m_latched ? (((cyc - m_entry) / BH) % 2 == 0) : 1'b0;
    chk("state",        32'(state),         32'(exp_st));
    chk("buzzer",       32'(buzzer),        32'(m_latched && !m_acked));
    chk("led",          32'(led),           32'(exp_led));
    chk("alarm_active", 32'(alarm_active),  32'(m_latched));
    chk("event_count",  32'(event_count),   32'((m_events > 255) ? 255 : m_events));
    chk("state_w2",     32'(state2),        32'(exp_st));
    chk("led_w2",       32'(led2),          32'(exp_led));
    chk("count_w2",     32'(event_count2),  32'((m_events > 3) ? 3 : m_events));
  endtask

  task automatic step(input bit a, input bit k);
    @(negedge clk);
    alarm_in = a;
    ack      = k;
    @(posedge clk);
    cyc++;
    model_edge(a, k);
    #1;
    check_all();
  endtask

  initial begin
    // Reset values
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Glitch rejection: three highs then low
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Confirmation, then blink through two half-periods
    repeat (DEB) step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b0);

    // Latching with alarm low and no ack
    repeat (20) step(1'b0, 1'b0);

    // Acknowledge with alarm high, stay ACKED, then clear
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Ack held across the confirming edge is ignored there, acts on the next edge
    repeat (DEB + 1) step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Asynchronous reset between edges while ACTIVE
    repeat (DEB + 2) step(1'b1, 1'b0);
    @(posedge clk);
    cyc++;
    model_edge(1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // Saturation of the 2-bit counter over five full cycles
    repeat (5) begin
      repeat (DEB) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end

    // Random traffic, alarm biased high so events actually confirm
    repeat (600) begin
      step(($urandom_range(0, 99) < 75), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
